// File: rtl/ultra_pkg.sv
// Shared definitions for the HC-SR04 trigger/echo path: responder FSM states and
// the distance-to-echo conversion constants that the controller also uses.
package ultra_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG_HI,
    ST_BURST,
    ST_ECHO,
    ST_HOLDOFF
  } ultra_state_e;

  localparam int unsigned US_PER_CM = 58;
  localparam int unsigned DIST_MAX  = 400;
  localparam int unsigned NO_OBJ_US = 38000;

  // Echo width in us for a given target; distance 0 is treated as "no object".
  function automatic logic [15:0] echo_len_us(
    input logic [8:0]  dist_cm,
    input logic        present,
    input int unsigned no_obj_us,
    input int unsigned us_per_cm,
    input int unsigned dist_max
  );
    logic [8:0] dist_clamped;
    if (!present || (dist_cm == '0)) begin
      return 16'(no_obj_us);
    end
    dist_clamped = (dist_cm > 9'(dist_max)) ? 9'(dist_max) : dist_cm;
    return 16'(dist_clamped) * 16'(us_per_cm);
  endfunction

endpackage

// File: rtl/tick_gen_us.sv
// Microsecond tick prescaler: pulses tick on the terminal count of a 0..TICK_DIV-1
// counter; clear restarts the period so the caller can align ticks to state entry.
module tick_gen_us #(
  parameter int unsigned TICK_DIV = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hcsr04_echo_responder.sv
// HC-SR04 sensor stand-in: accepts a validated trigger pulse, waits the burst
// delay, then returns an echo whose width encodes the emulated distance.
module hcsr04_echo_responder
  import ultra_pkg::*;
#(
  parameter int unsigned TICK_DIV       = 100,
  parameter int unsigned TRIG_MIN_US    = 10,
  parameter int unsigned BURST_DELAY_US = 200,
  parameter int unsigned US_PER_CM      = ultra_pkg::US_PER_CM,
  parameter int unsigned DIST_MAX       = ultra_pkg::DIST_MAX,
  parameter int unsigned NO_OBJ_US      = ultra_pkg::NO_OBJ_US,
  parameter int unsigned HOLDOFF_US     = 60000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger,
  input  logic [8:0] distance_cm,
  input  logic       object_present,
  output logic       echo,
  output logic       busy,
  output logic       trig_err
);

  ultra_state_e state_q, state_d;
  logic [15:0]  us_cnt_q, us_cnt_d;
  logic [15:0]  us_cnt_inc;
  logic [15:0]  echo_len_q, echo_len_d;
  logic         echo_q, echo_d;
  logic         busy_q, busy_d;
  logic         trig_err_q, trig_err_d;
  logic         trig_s1_q, trig_s2_q, trig_dly_q;
  logic         trig_rise, trig_fall;
  logic         tick;
  logic         tick_clear;

  // Edge detection uses only the second synchronizer stage and its delayed copy.
  assign trig_rise = trig_s2_q & ~trig_dly_q;
  assign trig_fall = ~trig_s2_q & trig_dly_q;

  tick_gen_us #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(tick_clear),
    .tick (tick)
  );

  assign us_cnt_inc = us_cnt_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    us_cnt_d   = us_cnt_q;
    echo_len_d = echo_len_q;
    trig_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (trig_rise) begin
          state_d  = ST_TRIG_HI;
          us_cnt_d = '0;
        end
      end

      ST_TRIG_HI: begin
        if (trig_fall) begin
          us_cnt_d = '0;
          if (us_cnt_q >= 16'(TRIG_MIN_US)) begin
            state_d    = ST_BURST;
            echo_len_d = echo_len_us(distance_cm, object_present, NO_OBJ_US,
                                     US_PER_CM, DIST_MAX);
          end else begin
            state_d    = ST_IDLE;
            trig_err_d = 1'b1;
          end
        end else if (tick && (us_cnt_q != '1)) begin
          us_cnt_d = us_cnt_inc;
        end
      end

      ST_BURST: begin
        if (tick) begin
          if (us_cnt_inc >= 16'(BURST_DELAY_US)) begin
            state_d  = ST_ECHO;
            us_cnt_d = '0;
          end else begin
            us_cnt_d = us_cnt_inc;
          end
        end
      end

      ST_ECHO: begin
        if (tick) begin
          if (us_cnt_inc >= echo_len_q) begin
            state_d  = ST_HOLDOFF;
            us_cnt_d = '0;
          end else begin
            us_cnt_d = us_cnt_inc;
          end
        end
      end

      ST_HOLDOFF: begin
        if (tick) begin
          if (us_cnt_inc >= 16'(HOLDOFF_US)) begin
            state_d  = ST_IDLE;
            us_cnt_d = '0;
          end else begin
            us_cnt_d = us_cnt_inc;
          end
        end
      end

      default: begin
        state_d  = ST_IDLE;
        us_cnt_d = '0;
      end
    endcase

    // Outputs follow the next state so they switch on the same edge as the FSM.
    tick_clear = (state_d != state_q);
    echo_d     = (state_d == ST_ECHO);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      us_cnt_q   <= '0;
      echo_len_q <= '0;
      echo_q     <= 1'b0;
      busy_q     <= 1'b0;
      trig_err_q <= 1'b0;
      trig_s1_q  <= 1'b0;
      trig_s2_q  <= 1'b0;
      trig_dly_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      us_cnt_q   <= us_cnt_d;
      echo_len_q <= echo_len_d;
      echo_q     <= echo_d;
      busy_q     <= busy_d;
      trig_err_q <= trig_err_d;
      trig_s1_q  <= trigger;
      trig_s2_q  <= trig_s1_q;
      trig_dly_q <= trig_s2_q;
    end
  end

  assign echo     = echo_q;
  assign busy     = busy_q;
  assign trig_err = trig_err_q;

endmodule

// File: tb/tb_hcsr04_echo_responder.sv
// Directed bench for hcsr04_echo_responder with TICK_DIV=2, BURST_DELAY_US=4,
// HOLDOFF_US=20 and a shortened no-object echo (1000 us) to keep runtime small.
module tb_hcsr04_echo_responder;

  localparam int LIMIT = 60000;

  logic       clk;
  logic       reset;
  logic       trigger;
  logic [8:0] distance_cm;
  logic       object_present;
  logic       echo;
  logic       busy;
  logic       trig_err;

  int n_checks;
  int n_fail;

  hcsr04_echo_responder #(
    .TICK_DIV      (2),
    .TRIG_MIN_US   (10),
    .BURST_DELAY_US(4),
    .NO_OBJ_US     (1000),
    .HOLDOFF_US    (20)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .trigger       (trigger),
    .distance_cm   (distance_cm),
    .object_present(object_present),
    .echo          (echo),
    .busy          (busy),
    .trig_err      (trig_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: trigger pulse of trig_clk cycles, then measure the delay
  // (edges from trigger fall to echo seen high), echo width and holdoff length.
  // mode 1: second trigger during ECHO/HOLDOFF plus distance change to 10 cm.
  // mode 2: trigger raised during HOLDOFF and left high.
  task automatic measure(input int trig_clk, input int mode,
                         output int dly, output int width, output int hold,
                         output logic busy_at_drop);
    @(posedge clk); #1;
    trigger = 1'b1;
    repeat (trig_clk) @(posedge clk);
    #1;
    busy_at_drop = busy;
    trigger = 1'b0;
    dly = 0; width = -1; hold = -1;
    while ((echo !== 1'b1) && (dly < 1000)) begin
      @(posedge clk); #1;
      dly++;
    end
    if (echo !== 1'b1) begin
      dly = -1;
      return;
    end
    width = 1;
    for (int i = 0; i < LIMIT; i++) begin
      @(posedge clk); #1;
      if (mode == 1) begin
        if (width == 50) trigger = 1'b1;
        if (width == 60) distance_cm = 9'd10;
        if (width == 80) trigger = 1'b0;
      end
      if (echo !== 1'b1) break;
      width++;
    end
    hold = (busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < 1000; i++) begin
      if (busy !== 1'b1) break;
      @(posedge clk); #1;
      if (mode == 1) begin
        if (hold == 5)  trigger = 1'b1;
        if (hold == 30) trigger = 1'b0;
      end
      if ((mode == 2) && (hold == 10)) trigger = 1'b1;
      if (busy !== 1'b1) break;
      hold++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; trigger = 1'b0; distance_cm = 9'd3; object_present = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (echo !== 1'b0) begin n_fail++; $display("FAIL reset_echo got %b want 0", echo); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++;
    if (trig_err !== 1'b0) begin n_fail++; $display("FAIL reset_trig_err got %b want 0", trig_err); end
    reset = 1'b0;
  endtask

  // 3 cm -> 174 us -> 348 clk; delay = 2 sync + 1 state edge + 8 burst = 11 clk.
  task automatic test_valid_echo;
    int d, w, h; logic b;
    distance_cm = 9'd3; object_present = 1'b1;
    measure(24, 0, d, w, h, b);
    n_checks++;
    if (b !== 1'b1) begin n_fail++; $display("FAIL valid_busy_trig got %b want 1", b); end
    n_checks++;
    if (d < 10 || d > 12) begin n_fail++; $display("FAIL valid_delay got %0d want 11+-1", d); end
    n_checks++;
    if (w < 347 || w > 349) begin n_fail++; $display("FAIL valid_width got %0d want 348", w); end
    n_checks++;
    if (h < 39 || h > 41) begin n_fail++; $display("FAIL valid_holdoff got %0d want 40", h); end
  endtask

  task automatic test_short_trigger;
    int err_cycles, echo_cycles;
    err_cycles = 0; echo_cycles = 0;
    @(posedge clk); #1;
    trigger = 1'b1;
    repeat (12) @(posedge clk);
    #1 trigger = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (trig_err === 1'b1) err_cycles++;
      if (echo === 1'b1) echo_cycles++;
    end
    n_checks++;
    if (err_cycles != 1) begin n_fail++; $display("FAIL short_trig_err got %0d cycles want 1", err_cycles); end
    n_checks++;
    if (echo_cycles != 0) begin n_fail++; $display("FAIL short_echo got %0d cycles want 0", echo_cycles); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL short_idle busy got %b want 0", busy); end
  endtask

  // No object (1000 us -> 2000 clk) both via object_present=0 and distance 0.
  task automatic test_no_object;
    int d, w, h; logic b;
    distance_cm = 9'd3; object_present = 1'b0;
    measure(24, 0, d, w, h, b);
    n_checks++;
    if (w < 1999 || w > 2001) begin n_fail++; $display("FAIL noobj_width got %0d want 2000", w); end
    distance_cm = 9'd0; object_present = 1'b1;
    measure(24, 0, d, w, h, b);
    n_checks++;
    if (w < 1999 || w > 2001) begin n_fail++; $display("FAIL dist0_width got %0d want 2000", w); end
  endtask

  // 500 cm clamps to 400 cm -> 23200 us -> 46400 clk.
  task automatic test_clamp;
    int d, w, h; logic b;
    distance_cm = 9'd500 - 9'd0; object_present = 1'b1;
    distance_cm = 9'h1F4;
    measure(24, 0, d, w, h, b);
    n_checks++;
    if (w < 46399 || w > 46401) begin n_fail++; $display("FAIL clamp_width got %0d want 46400", w); end
  endtask

  task automatic test_distance_change;
    int d, w, h, busy_cycles; logic b;
    distance_cm = 9'd3; object_present = 1'b1;
    measure(24, 1, d, w, h, b);
    n_checks++;
    if (w < 347 || w > 349) begin n_fail++; $display("FAIL chg_width got %0d want 348", w); end
    busy_cycles = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b1 || echo === 1'b1) busy_cycles++;
    end
    n_checks++;
    if (busy_cycles != 0) begin n_fail++; $display("FAIL chg_ignored_trig got %0d busy cycles want 0", busy_cycles); end
    measure(24, 0, d, w, h, b);
    n_checks++;
    if (w < 1159 || w > 1161) begin n_fail++; $display("FAIL chg_next_width got %0d want 1160", w); end
  endtask

  task automatic test_reset_mid_echo;
    int d, w, h, n; logic b;
    distance_cm = 9'd3; object_present = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b1;
    repeat (24) @(posedge clk);
    #1 trigger = 1'b0;
    n = 0;
    while ((echo !== 1'b1) && (n < 1000)) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (echo !== 1'b1) begin n_fail++; $display("FAIL rst_mid_rise got %b want 1", echo); end
    repeat (100) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (echo !== 1'b0) begin n_fail++; $display("FAIL rst_mid_echo got %b want 0", echo); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    reset = 1'b0;
    measure(24, 0, d, w, h, b);
    n_checks++;
    if (w < 347 || w > 349) begin n_fail++; $display("FAIL rst_after_width got %0d want 348", w); end
  endtask

  task automatic test_trigger_held;
    int d, w, h, busy_cycles; logic b;
    distance_cm = 9'd3; object_present = 1'b1;
    measure(24, 2, d, w, h, b);
    n_checks++;
    if (trigger !== 1'b1) begin n_fail++; $display("FAIL held_setup trigger got %b want 1", trigger); end
    busy_cycles = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b1) busy_cycles++;
    end
    trigger = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b1) busy_cycles++;
    end
    n_checks++;
    if (busy_cycles != 0) begin n_fail++; $display("FAIL held_no_start got %0d busy cycles want 0", busy_cycles); end
    measure(24, 0, d, w, h, b);
    n_checks++;
    if (w < 347 || w > 349) begin n_fail++; $display("FAIL held_fresh_width got %0d want 348", w); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; trigger = 1'b0; distance_cm = 9'd3; object_present = 1'b1;
    test_reset();
    test_valid_echo();
    test_short_trigger();
    test_no_object();
    test_clamp();
    test_distance_change();
    test_reset_mid_echo();
    test_trigger_held();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
